adder_stim_checker: RTL and testbench

Initiator-side companion for the registered 4-bit adder. It drives operand pairs and `valid` into the adder, captures the adder's result a fixed number of cycles later, and compares it against an internally computed expected sum. It sweeps every operand combination exhaustively and reports pass/fail, an error count, and the first failing transaction. It sits beside the adder as a built-in self-test block and is also reused as the stimulus/check harness in benches.

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_exp_pipe.sv | 37 +++
 rtl/adder_stim_checker.sv | 143 ++++++++++++++
 tb/tb_adder_stim_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths and types for the 4-bit adder, its checker and benches
package adder_pkg;

  localparam int ADD_W  = 4;
  localparam int ADD_RW = 7;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

  typedef logic [ADD_RW-1:0] add_res_t;

endpackage

// File: rtl/adder_exp_pipe.sv
// rtl/adder_exp_pipe.sv - LAT-deep delay line carrying {valid, a, b, expected} alongside the adder
module adder_exp_pipe
  import adder_pkg::*;
#(
  parameter int W   = ADD_W,
  parameter int RW  = ADD_RW,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [RW-1:0] exp_i,
  output logic          vld_o,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic [RW-1:0] exp_o
);

  localparam int DW = 1 + 2*W + RW;

  logic [DW-1:0] stage_q [LAT];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {vld_i, a_i, b_i, exp_i};
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {vld_o, a_o, b_o, exp_o} = stage_q[LAT-1];

endmodule

// File: rtl/adder_stim_checker.sv
// rtl/adder_stim_checker.sv - exhaustive operand sweep and result checker for the registered adder
module adder_stim_checker
  import adder_pkg::*;
#(
  parameter int W   = ADD_W,
  parameter int RW  = ADD_RW,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic          valid_o,
  input  logic [RW-1:0] c_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [W-1:0]  fail_a,
  output logic [W-1:0]  fail_b,
  output logic [RW-1:0] fail_c
);

  chk_state_t      state_q, state_d;
  logic [2*W-1:0]  idx_q, idx_d;
  logic [3:0]      drain_q, drain_d;
  logic [15:0]     err_q, err_d;
  logic            seen_q, seen_d;
  logic [W-1:0]    fa_q, fa_d, fb_q, fb_d;
  logic [RW-1:0]   fc_q, fc_d;

  logic            start_acc;
  logic            p_vld;
  logic [W-1:0]    p_a, p_b;
  logic [RW-1:0]   p_exp, exp_sum;
  logic            mismatch;

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign exp_sum   = RW'(a_o) + RW'(b_o);
  assign mismatch  = p_vld && (c_i != p_exp);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == '1) state_d = DRAIN;
      DRAIN:   if (drain_q == 4'(LAT-1)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == RUN);
    busy    = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    pass    = (state_q == DONE) && (err_q == 16'd0);
    a_o     = valid_o ? idx_q[W-1:0]   : '0;
    b_o     = valid_o ? idx_q[2*W-1:W] : '0;
  end

  always_comb begin
    idx_d   = idx_q;
    drain_d = drain_q;
    err_d   = err_q;
    seen_d  = seen_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fc_d    = fc_q;
    if (start_acc) begin
      idx_d   = '0;
      drain_d = '0;
      err_d   = '0;
      seen_d  = 1'b0;
      fa_d    = '0;
      fb_d    = '0;
      fc_d    = '0;
    end else begin
      if (state_q == RUN && idx_q != '1) idx_d = idx_q + (2*W)'(1);
      if (state_q == DRAIN) drain_d = drain_q + 4'd1;
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        // only the first failing transaction is kept for diagnosis
        if (!seen_q) begin
          seen_d = 1'b1;
          fa_d   = p_a;
          fb_d   = p_b;
          fc_d   = c_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      seen_q  <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fc_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
    end
  end

  adder_exp_pipe #(
    .W   (W),
    .RW  (RW),
    .LAT (LAT)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .vld_i (valid_o),
    .a_i   (a_o),
    .b_i   (b_o),
    .exp_i (exp_sum),
    .vld_o (p_vld),
    .a_o   (p_a),
    .b_o   (p_b),
    .exp_o (p_exp)
  );

  assign err_cnt = err_q;
  assign fail_a  = fa_q;
  assign fail_b  = fb_q;
  assign fail_c  = fc_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb/tb_adder_stim_checker.sv - bench for adder_stim_checker with adder models and a cycle-level reference
module tb_adder_stim_checker;
  import adder_pkg::*;

  localparam int W     = ADD_W;
  localparam int RW    = ADD_RW;
  localparam int LAT1  = 1;
  localparam int LAT2  = 3;
  localparam int NPAIR = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;
  logic [W-1:0] a1, b1, fa1, fb1, a2, b2, fa2, fb2;
  logic v1, busy1, done1, pass1, v2, busy2, done2, pass2;
  add_res_t c1_i, c2_i, fc1, fc2;
  logic [15:0] err1, err2;

  adder_stim_checker #(.W(W), .RW(RW), .LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .valid_o(v1),
    .c_i(c1_i), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_a(fa1), .fail_b(fb1), .fail_c(fc1)
  );

  adder_stim_checker #(.W(W), .RW(RW), .LAT(LAT2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .valid_o(v2),
    .c_i(c2_i), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_a(fa2), .fail_b(fb2), .fail_c(fc2)
  );

  // adder models: 0 golden, 1 bit4 stuck at 0, 2 always zero, 3 three-cycle delay
  int mode;
  add_res_t r1, r2, r3, q1, q2, q3;
  always @(posedge clk) begin
    r1 <= RW'(a1) + RW'(b1);
    r2 <= r1;
    r3 <= r2;
    q1 <= RW'(a2) + RW'(b2);
    q2 <= q1;
    q3 <= q2;
  end
  always_comb begin
    c1_i = r1;
    case (mode)
      1:       c1_i[4] = 1'b0;
      2:       c1_i = '0;
      3:       c1_i = r3;
      default: c1_i = r1;
    endcase
  end
  assign c2_i = q3;

  int m_chk = 0, m_pass = 0, h_chk = 0, h_pass = 0;
  bit chk_en = 1'b0;

  // reference: mn is the cycle number within the sweep (0 = idle)
  int mn = 0, merr = 0, mfa = 0, mfb = 0, mfc = 0;
  bit mdone = 1'b0, mseen = 1'b0;

  always @(negedge clk) begin : ref_model
    int k, sum, ea, eb;
    bit running, vld;
    logic [42:0] got_v, exp_v;
    if (chk_en) begin
      running = (mn >= 1) && (mn <= NPAIR + LAT1);
      vld     = (mn >= 1) && (mn <= NPAIR);
      ea      = vld ? (mn - 1) % 16 : 0;
      eb      = vld ? (mn - 1) / 16 : 0;
      got_v   = {busy1, v1, a1, b1, done1, pass1, err1, fa1, fb1, fc1};
      exp_v   = {running, vld, W'(ea), W'(eb), mdone, (mdone && merr == 0),
                 16'(merr), W'(mfa), W'(mfb), RW'(mfc)};
      m_chk++;
      if (got_v !== exp_v)
        $display("FAIL model_cycle n=%0d got=%h exp=%h", mn, got_v, exp_v);
      else
        m_pass++;
    end
    if (rst) begin
      mn = 0; mdone = 0; merr = 0; mseen = 0; mfa = 0; mfb = 0; mfc = 0;
    end else if ((mn == 0 || mdone) && start) begin
      mn = 1; mdone = 0; merr = 0; mseen = 0; mfa = 0; mfb = 0; mfc = 0;
    end else if (mn >= 1 && !mdone) begin
      if (mn >= 1 + LAT1) begin
        k   = mn - 1 - LAT1;
        sum = (k % 16) + (k / 16);
        if (int'(c1_i) != sum) begin
          if (merr < 65535) merr++;
          if (!mseen) begin
            mseen = 1; mfa = k % 16; mfb = k / 16; mfc = int'(c1_i);
          end
        end
      end
      mn++;
      if (mn > NPAIR + LAT1) mdone = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    h_chk++;
    if (got !== expv) $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    else h_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // leaves the bench at cycle 1 of the new sweep
  task automatic pulse_start(input bit both);
    start = 1'b1;
    if (both) start2 = 1'b1;
    tick(1);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
    tick(4);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", 32'(v1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_a", 32'(a1), 0);

    // golden adder, both latencies
    pulse_start(1'b1);
    check("c1_busy", 32'(busy1), 1);
    check("c1_a", 32'(a1), 0);
    tick(16);
    check("c17_a", 32'(a1), 0);
    check("c17_b", 32'(b1), 1);
    tick(240);
    check("c257_busy", 32'(busy1), 1);
    check("c257_done", 32'(done1), 0);
    tick(1);
    check("c258_done", 32'(done1), 1);
    check("c258_pass", 32'(pass1), 1);
    check("c258_err", 32'(err1), 0);
    check("lat3_c258_done", 32'(done2), 0);
    tick(1);
    check("lat3_c259_done", 32'(done2), 0);
    tick(1);
    check("lat3_c260_done", 32'(done2), 1);
    check("lat3_pass", 32'(pass2), 1);
    check("lat3_err", 32'(err2), 0);

    // bit 4 stuck low
    mode = 1;
    pulse_start(1'b0);
    tick(257);
    check("stuck_done", 32'(done1), 1);
    check("stuck_err", 32'(err1), 120);
    check("stuck_pass", 32'(pass1), 0);
    check("stuck_fa", 32'(fa1), 15);
    check("stuck_fb", 32'(fb1), 1);
    check("stuck_fc", 32'(fc1), 0);

    // adder always zero
    mode = 2;
    pulse_start(1'b0);
    tick(257);
    check("zero_err", 32'(err1), 255);
    check("zero_fa", 32'(fa1), 1);
    check("zero_fb", 32'(fb1), 0);
    check("zero_fc", 32'(fc1), 0);

    // three-cycle adder against LAT=1 checker
    mode = 3;
    pulse_start(1'b0);
    tick(257);
    check("delay_err_nonzero", 32'(err1 != 16'd0), 1);
    check("delay_pass", 32'(pass1), 0);

    // reset mid-run
    mode = 2;
    pulse_start(1'b0);
    tick(99);
    check("c100_err", 32'(err1), 97);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(v1), 0);
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_err", 32'(err1), 0);
    mode = 0;
    tick(2);
    pulse_start(1'b0);
    tick(257);
    check("after_rst_pass", 32'(pass1), 1);

    // start pulses during RUN and DRAIN are ignored
    pulse_start(1'b0);
    tick(49);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(206);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ign_done", 32'(done1), 1);
    check("ign_pass", 32'(pass1), 1);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_done", 32'(done1), 0);
    check("restart_valid", 32'(v1), 1);
    tick(257);
    check("restart_pass", 32'(pass1), 1);

    // start held high continuously
    start = 1'b1;
    tick(1);
    tick(257);
    check("hold_done", 32'(done1), 1);
    tick(1);
    check("hold_done_drop", 32'(done1), 0);
    check("hold_busy", 32'(busy1), 1);
    start = 1'b0;
    tick(257);
    check("hold_pass", 32'(pass1), 1);

    tick(2);
    $display("%0d/%0d checks passed", h_pass + m_pass, h_chk + m_chk);
    $finish;
  end

endmodule
